pipe_stage_latch: RTL and testbench

- Generic, parametrised inter-stage pipeline register for the pipelined datapath. Successor to the fixed-field stage latches.
- Carries one opaque payload of DATA_W bits. Stage-specific fields are packed by the instantiating stage.
- Adds what the fixed latches lack: valid/ready elastic handshake, stall hold, synchronous flush, an optional 2-entry skid buffer for full throughput with registered in_ready, and a saturating backpressure counter.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_sat_counter.sv | 23 ++
 rtl/pipe_stage_latch.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_latch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for the pipeline stage latches.
package pipe_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // Payload layouts that stages pack into in_data.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_payload_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_wr;
        logic [31:0] alu_res;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter with synchronous clear.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // clr wins over inc; the count parks at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_latch.sv
// rtl/pipe_stage_latch.sv - elastic inter-stage register with stall, flush,
// optional two-entry skid buffer and a backpressure counter.
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = DEFAULT_DATA_W,
    parameter int                SKID    = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_cnt,
    input  logic              bp_clr
);

    stage_state_t      state_q, state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_data;
    logic              ready_raw;
    logic              load_main;
    logic              main_from_skid;
    logic              accept;
    logic              consume;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            main_q <= RST_VAL;
        end else if (load_main) begin
            main_q <= in_data;
        end else if (main_from_skid) begin
            main_q <= skid_data;
        end
    end

    // Stall and flush gate both handshakes, so neither side can transfer.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!flush && !stall) begin
            in_ready  = ready_raw & nRST;
            out_valid = (state_q != EMPTY);
        end
    end

    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign out_data  = main_q;
    assign occupancy = state_q;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_q;
            logic              ready_q;
            logic              load_skid;

            // in_ready comes straight from a flop to cut the upstream ready path.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    skid_q  <= RST_VAL;
                    ready_q <= 1'b1;
                end else begin
                    if (load_skid) begin
                        skid_q <= in_data;
                    end
                    ready_q <= (state_d != TWO);
                end
            end

            assign skid_data = skid_q;
            assign ready_raw = ready_q;

            always_comb begin
                state_d        = state_q;
                load_main      = 1'b0;
                main_from_skid = 1'b0;
                load_skid      = 1'b0;
                if (flush) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY: if (accept) begin
                            state_d   = ONE;
                            load_main = 1'b1;
                        end
                        ONE: begin
                            if (accept && consume) begin
                                load_main = 1'b1;
                            end else if (accept) begin
                                state_d   = TWO;
                                load_skid = 1'b1;
                            end else if (consume) begin
                                state_d = EMPTY;
                            end
                        end
                        TWO: if (consume) begin
                            state_d        = ONE;
                            main_from_skid = 1'b1;
                        end
                        default: state_d = EMPTY;
                    endcase
                end
            end
        end else begin : g_single
            assign skid_data = RST_VAL;
            assign ready_raw = (state_q == EMPTY) | out_ready;

            always_comb begin
                state_d        = state_q;
                load_main      = 1'b0;
                main_from_skid = 1'b0;
                if (flush) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
        end
    endgenerate

    pipe_sat_counter #(.W(CNT_W)) u_bp_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (out_valid & ~out_ready),
        .clr  (bp_clr),
        .cnt  (bp_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb/tb_pipe_stage_latch.sv - directed bench for pipe_stage_latch (SKID=1 and SKID=0).
module tb_pipe_stage_latch;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       flush, stall, in_valid, out_ready, bp_clr;
    logic [7:0] in_data;

    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [1:0] occupancy;
    logic [3:0] bp_cnt;

    logic       s0_in_ready, s0_out_valid;
    logic [7:0] s0_out_data;
    logic [1:0] s0_occupancy;
    logic [3:0] s0_bp_cnt;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pipe_stage_latch #(.DATA_W(8), .SKID(1), .RST_VAL(8'hA5), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .bp_cnt(bp_cnt), .bp_clr(bp_clr)
    );

    pipe_stage_latch #(.DATA_W(8), .SKID(0), .RST_VAL(8'hA5), .CNT_W(4)) dut_s0 (
        .CLK(CLK), .nRST(nRST), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(s0_in_ready), .in_data(in_data),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_data(s0_out_data),
        .occupancy(s0_occupancy), .bp_cnt(s0_bp_cnt), .bp_clr(bp_clr)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; flush = 0; stall = 0; in_valid = 0; out_ready = 0; bp_clr = 0; in_data = 8'h00;
        step(); step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (bp_cnt !== 4'd0) begin errors++; $display("FAIL reset_bp got=%0d exp=0", bp_cnt); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL reset_data got=%h exp=a5", out_data); end
        checks++; if (s0_in_ready !== 1'b0) begin errors++; $display("FAIL reset_s0_in_ready got=%b exp=0", s0_in_ready); end
        nRST = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_fill();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vals[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d] got=%b exp=1", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== vals[i])
                begin errors++; $display("FAIL fill_out[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, vals[i]); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drain got=%b exp=0", out_valid); end
        checks++; if (bp_cnt !== 4'd0) begin errors++; $display("FAIL fill_bp got=%0d exp=0", bp_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0A;
        step();
        in_data = 8'h0B;
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2 got=%0d exp=2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_data !== 8'h0A || out_valid !== 1'b1) begin errors++; $display("FAIL bp_head got=%b/%h exp=1/0a", out_valid, out_data); end
        checks++; if (bp_cnt !== 4'd1) begin errors++; $display("FAIL bp_cnt1 got=%0d exp=1", bp_cnt); end
        step();
        checks++; if (out_data !== 8'h0A || bp_cnt !== 4'd2) begin errors++; $display("FAIL bp_hold got=%h/%0d exp=0a/2", out_data, bp_cnt); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 8'h0B || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second got=%b/%h exp=1/0b", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_reopen got=%b/%0d exp=1/1", in_ready, occupancy); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
        bp_clr = 1'b1;
        step();
        bp_clr = 1'b0;
        checks++; if (bp_cnt !== 4'd0) begin errors++; $display("FAIL bp_clr got=%0d exp=0", bp_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        step();
        in_data = 8'h02;
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fl_pre_occ got=%0d exp=2", occupancy); end
        flush   = 1'b1;
        in_data = 8'h0C;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fl_force got=%b/%b exp=0/0", in_ready, out_valid); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fl_empty got=%0d/%b exp=0/0", occupancy, out_valid); end
        checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL fl_payload_hold got=%h exp=01", out_data); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_0c[%0d] got=%b/%h exp=0", i, out_valid, out_data); end
        end
        bp_clr = 1'b1;
        step();
        bp_clr = 1'b0;
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        step();
        in_valid = 1'b0;
        stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL st_force[%0d] got=%b/%b exp=0/0", i, out_valid, in_ready); end
            checks++; if (bp_cnt !== 4'd0 || occupancy !== 2'd1) begin errors++; $display("FAIL st_hold[%0d] got=%0d/%0d exp=0/1", i, bp_cnt, occupancy); end
            step();
        end
        stall = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin errors++; $display("FAIL st_release got=%b/%h exp=1/55", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_once got=%b exp=0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h66;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        checks++; if (bp_cnt !== 4'd15) begin errors++; $display("FAIL sat_15 got=%0d exp=15", bp_cnt); end
        step(); step();
        checks++; if (bp_cnt !== 4'd15) begin errors++; $display("FAIL sat_stay got=%0d exp=15", bp_cnt); end
        bp_clr = 1'b1;
        step();
        bp_clr = 1'b0;
        checks++; if (bp_cnt !== 4'd0) begin errors++; $display("FAIL sat_clr_prio got=%0d exp=0", bp_cnt); end
        step();
        checks++; if (bp_cnt !== 4'd1) begin errors++; $display("FAIL sat_recount got=%0d exp=1", bp_cnt); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_skid0();
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h07;
        #1;
        checks++; if (s0_in_ready !== 1'b1) begin errors++; $display("FAIL s0_empty_ready got=%b exp=1", s0_in_ready); end
        step();
        checks++; if (s0_out_valid !== 1'b1 || s0_out_data !== 8'h07) begin errors++; $display("FAIL s0_full got=%b/%h exp=1/07", s0_out_valid, s0_out_data); end
        out_ready = 1'b1;
        in_data   = 8'h08;
        #1;
        checks++; if (s0_in_ready !== 1'b1) begin errors++; $display("FAIL s0_pass_ready got=%b exp=1", s0_in_ready); end
        step();
        checks++; if (s0_out_data !== 8'h08 || s0_occupancy !== 2'd1) begin errors++; $display("FAIL s0_replace got=%h/%0d exp=08/1", s0_out_data, s0_occupancy); end
        out_ready = 1'b0;
        in_data   = 8'h09;
        #1;
        checks++; if (s0_in_ready !== 1'b0) begin errors++; $display("FAIL s0_block got=%b exp=0", s0_in_ready); end
        step();
        checks++; if (s0_out_data !== 8'h08) begin errors++; $display("FAIL s0_hold got=%h exp=08", s0_out_data); end
        in_valid = 1'b0;
        nRST = 1'b0;
        #1;
        checks++; if (s0_occupancy !== 2'd0 || occupancy !== 2'd0) begin errors++; $display("FAIL mid_reset got=%0d/%0d exp=0/0", s0_occupancy, occupancy); end
        nRST = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_flush();
        test_stall();
        test_saturation();
        test_skid0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
